// File: rtl/red_pitaya_trigger_sequencer.sv
// Multi-shot trigger sequencer: arms the trigger block, timestamps each trigger into a FIFO,
// applies holdoff between shots and an optional wait timeout; registers on a simple ack bus.
module red_pitaya_trigger_sequencer #(
  parameter int FIFODEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        trig_i,
  output logic        rearm_o,
  output logic        busy_o,
  output logic        done_o,
  input  logic [15:0] addr,
  input  logic        wen,
  input  logic        ren,
  output logic        ack,
  output logic [31:0] rdata,
  input  logic [31:0] wdata
);

  localparam int AW = $clog2(FIFODEPTH);
  localparam logic [4:0] DEPTH_C = 5'(FIFODEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ARM = 3'd1, S_WAIT = 3'd2, S_HOLDOFF = 3'd3, S_DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     ts_q, ts_d;
  logic [15:0]     ntrig_q, ntrig_d, ntrig_act_q, ntrig_act_d;
  logic [31:0]     holdoff_q, holdoff_d, hold_act_q, hold_act_d;
  logic [31:0]     timeout_q, timeout_d, tmo_act_q, tmo_act_d;
  logic [31:0]     timer_q, timer_d;
  logic [15:0]     trig_cnt_q, trig_cnt_d;
  logic            tmo_flag_q, tmo_flag_d, ovf_q, ovf_d, done_q, done_d, ack_q, ack_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     mem_q [FIFODEPTH];
  logic [31:0]     mem_d [FIFODEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]      cnt_q, cnt_d;

  logic start, abort, fifo_empty, fifo_full;
  logic push, push_ok, pop, clr;

  assign start      = wen && (addr == 16'h0000) && wdata[0];
  assign abort      = wen && (addr == 16'h0000) && wdata[1];
  assign fifo_empty = (cnt_q == 5'd0);
  assign fifo_full  = (cnt_q == DEPTH_C);

  assign rearm_o = (state_q == S_ARM);
  assign busy_o  = (state_q == S_ARM) || (state_q == S_WAIT) || (state_q == S_HOLDOFF);
  assign done_o  = done_q;
  assign ack     = ack_q;
  assign rdata   = rdata_q;

  always_comb begin
    state_d     = state_q;
    ts_d        = ts_q + 32'd1;
    ntrig_d     = ntrig_q;
    holdoff_d   = holdoff_q;
    timeout_d   = timeout_q;
    ntrig_act_d = ntrig_act_q;
    hold_act_d  = hold_act_q;
    tmo_act_d   = tmo_act_q;
    timer_d     = timer_q;
    trig_cnt_d  = trig_cnt_q;
    tmo_flag_d  = tmo_flag_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    ack_d       = wen | ren;
    rdata_d     = 32'd0;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    push        = 1'b0;
    push_ok     = 1'b0;
    pop         = 1'b0;
    clr         = 1'b0;

    if (wen) begin
      case (addr)
        16'h0004: ntrig_d   = wdata[15:0];
        16'h0008: holdoff_d = wdata;
        16'h000C: timeout_d = wdata;
        default: ;
      endcase
    end

    if (ren) begin
      case (addr)
        16'h0000: rdata_d = {24'd0, cnt_q, state_q};
        16'h0004: rdata_d = {16'd0, ntrig_q};
        16'h0008: rdata_d = holdoff_q;
        16'h000C: rdata_d = timeout_q;
        16'h0010: rdata_d = {14'd0, tmo_flag_q, ovf_q, trig_cnt_q};
        16'h0014: begin
          rdata_d = fifo_empty ? 32'd0 : mem_q[rd_ptr_q];
          pop     = !fifo_empty;
        end
        default: rdata_d = 32'd0;
      endcase
    end

    // Abort outranks everything, including a trigger in the same cycle.
    case (state_q)
      S_IDLE, S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d    = S_ARM;
          trig_cnt_d = 16'd0;
          tmo_flag_d = 1'b0;
          ovf_d      = 1'b0;
          clr        = 1'b1;
        end
      end
      S_ARM: begin
        state_d     = abort ? S_IDLE : S_WAIT;
        ntrig_act_d = ntrig_q;
        hold_act_d  = holdoff_q;
        tmo_act_d   = timeout_q;
        timer_d     = 32'd0;
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (trig_i) begin
          push       = 1'b1;
          trig_cnt_d = (trig_cnt_q == 16'hFFFF) ? trig_cnt_q : trig_cnt_q + 16'd1;
          timer_d    = 32'd0;
          if ((ntrig_act_q != 16'd0) && ({1'b0, trig_cnt_q} + 17'd1 == {1'b0, ntrig_act_q})) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_HOLDOFF;
          end
        end else if ((tmo_act_q != 32'd0) && (timer_q == tmo_act_q - 32'd1)) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          tmo_flag_d = 1'b1;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_HOLDOFF: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if ((hold_act_q == 32'd0) || (timer_q >= hold_act_q - 32'd1)) begin
          state_d = S_ARM;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = 5'd0;
    end else begin
      push_ok = push && (!fifo_full || pop);
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok) begin
        mem_d[wr_ptr_q] = ts_q;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else if (push) begin
        ovf_d = 1'b1;
      end
      cnt_d = cnt_q + {4'd0, push_ok} - {4'd0, pop};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ts_q        <= 32'd0;
      ntrig_q     <= 16'd0;
      holdoff_q   <= 32'd0;
      timeout_q   <= 32'd0;
      ntrig_act_q <= 16'd0;
      hold_act_q  <= 32'd0;
      tmo_act_q   <= 32'd0;
      timer_q     <= 32'd0;
      trig_cnt_q  <= 16'd0;
      tmo_flag_q  <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= 32'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= 5'd0;
      for (int i = 0; i < FIFODEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_d;
      ntrig_q     <= ntrig_d;
      holdoff_q   <= holdoff_d;
      timeout_q   <= timeout_d;
      ntrig_act_q <= ntrig_act_d;
      hold_act_q  <= hold_act_d;
      tmo_act_q   <= tmo_act_d;
      timer_q     <= timer_d;
      trig_cnt_q  <= trig_cnt_d;
      tmo_flag_q  <= tmo_flag_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      mem_q       <= mem_d;
    end
  end

endmodule

// File: tb/tb_red_pitaya_trigger_sequencer.sv
// Bench for the trigger sequencer: randomized shot timing against a queue-based reference model.
module tb_red_pitaya_trigger_sequencer;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig_i;
  logic        rearm_o, busy_o, done_o;
  logic [15:0] addr;
  logic        wen, ren, ack;
  logic [31:0] rdata, wdata;

  red_pitaya_trigger_sequencer #(.FIFODEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .trig_i(trig_i), .rearm_o(rearm_o), .busy_o(busy_o),
    .done_o(done_o), .addr(addr), .wen(wen), .ren(ren), .ack(ack), .rdata(rdata), .wdata(wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Cycle index since reset release; equals the timestamp the DUT should capture.
  logic [31:0] cyc;
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 32'd0;
    else     cyc <= cyc + 32'd1;

  int          done_cnt = 0;
  int          rearm_cnt = 0;
  logic [31:0] last_done_cyc = 32'd0;
  always @(posedge clk) begin
    #1;
    if (done_o) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (rearm_o) rearm_cnt++;
  end

  // Reference model: FIFO as a queue plus shot counter and flags.
  logic [31:0] mq[$];
  logic [15:0] m_cnt;
  logic        m_ovf;
  logic        last_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("%s check did not match", tag);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_cnt = 16'd0;
    m_ovf = 1'b0;
  endtask

  task automatic model_push(input logic [31:0] ts);
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (mq.size() < DEPTH) mq.push_back(ts);
    else m_ovf = 1'b1;
  endtask

  function automatic logic [31:0] exp_status(input logic tmo);
    return {14'd0, tmo, m_ovf, m_cnt};
  endfunction

  function automatic logic [31:0] exp_ctrl(input logic [2:0] st);
    logic [4:0] n;
    n = 5'(mq.size());
    return {24'd0, n, st};
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wen = 1'b1;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; ren = 1'b1;
    @(negedge clk);
    ren = 1'b0;
    d = rdata;
    last_ack = ack;
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] d, e;
    bus_read(16'h0014, d);
    e = (mq.size() > 0) ? mq.pop_front() : 32'd0;
    chk(tag, d, e);
  endtask

  task automatic wait_rearm(output logic [31:0] c, output logic ok);
    ok = 1'b0;
    c  = 32'd0;
    for (int i = 0; i < 400; i++) begin
      if (rearm_o) begin
        c = cyc; ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int base, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (done_cnt > base) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_trig(input int d, output logic [31:0] tv);
    repeat (d) @(negedge clk);
    trig_i = 1'b1;
    tv = cyc;
    @(negedge clk);
    trig_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c, prev_c, tv, rd;
    logic        ok;
    int          h, hmin, d, dprev, t, base_d, base_r;

    rst = 1'b1; trig_i = 1'b0; wen = 1'b0; ren = 1'b0; addr = 16'd0; wdata = 32'd0;
    prev_c = 32'd0; dprev = 0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_rearm", {31'd0, rearm_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    bus_read(16'h0000, rd); chk("rst_ctrl", rd, 32'd0);
    bus_read(16'h0010, rd); chk("rst_status", rd, 32'd0);

    // Three shots with holdoff; a stray start and trigger during holdoff must be ignored.
    h = $urandom_range(6, 20);
    hmin = (h == 0) ? 1 : h;
    bus_write(16'h0004, 32'd3);
    bus_write(16'h0008, 32'(h));
    bus_write(16'h000C, 32'd0);
    bus_read(16'h0008, rd); chk("s1_holdoff_rb", rd, 32'(h));
    model_clear();
    base_d = done_cnt; base_r = rearm_cnt;
    bus_write(16'h0000, 32'd1);
    for (int k = 0; k < 3; k++) begin
      wait_rearm(c, ok);
      chk("s1_rearm_seen", {31'd0, ok}, 32'd1);
      if (k > 0) chk("s1_rearm_spacing", c - prev_c, 32'(dprev + hmin + 1));
      d = $urandom_range(1, 6);
      pulse_trig(d, tv);
      model_push(tv);
      if (k == 0) begin
        @(negedge clk); trig_i = 1'b1;
        @(negedge clk); trig_i = 1'b0;
        bus_write(16'h0000, 32'd1);
      end
      prev_c = c; dprev = d;
    end
    wait_done(base_d, ok);
    chk("s1_done_seen", {31'd0, ok}, 32'd1);
    chk("s1_done_cycle", last_done_cyc, tv + 32'd1);
    repeat (4) @(negedge clk);
    chk("s1_done_once", 32'(done_cnt - base_d), 32'd1);
    chk("s1_rearm_total", 32'(rearm_cnt - base_r), 32'd3);
    bus_read(16'h0010, rd); chk("s1_status", rd, exp_status(1'b0));
    bus_read(16'h0000, rd); chk("s1_ctrl", rd, exp_ctrl(3'd4));
    for (int k = 0; k < 4; k++) pop_check("s1_pop");

    // Timeout with no triggers.
    t = $urandom_range(30, 150);
    bus_write(16'h0004, 32'd0);
    bus_write(16'h000C, 32'(t));
    model_clear();
    base_d = done_cnt;
    bus_write(16'h0000, 32'd1);
    wait_rearm(c, ok);
    chk("s2_rearm_seen", {31'd0, ok}, 32'd1);
    wait_done(base_d, ok);
    chk("s2_done_seen", {31'd0, ok}, 32'd1);
    chk("s2_done_cycle", last_done_cyc, c + 32'd1 + 32'(t));
    bus_read(16'h0010, rd); chk("s2_status", rd, exp_status(1'b1));
    bus_read(16'h0000, rd); chk("s2_ctrl", rd, exp_ctrl(3'd4));
    bus_write(16'h000C, 32'd0);

    // Ten shots into an eight-deep FIFO with no pops.
    bus_write(16'h0004, 32'd10);
    bus_write(16'h0008, 32'd0);
    model_clear();
    base_d = done_cnt;
    bus_write(16'h0000, 32'd1);
    for (int k = 0; k < 10; k++) begin
      wait_rearm(c, ok);
      chk("s3_rearm_seen", {31'd0, ok}, 32'd1);
      pulse_trig($urandom_range(1, 4), tv);
      model_push(tv);
    end
    wait_done(base_d, ok);
    chk("s3_done_seen", {31'd0, ok}, 32'd1);
    bus_read(16'h0010, rd); chk("s3_status", rd, exp_status(1'b0));
    bus_read(16'h0000, rd); chk("s3_ctrl", rd, exp_ctrl(3'd4));
    for (int k = 0; k < DEPTH + 1; k++) pop_check("s3_pop");

    // Push with a pop of the empty FIFO, then abort coinciding with a trigger.
    bus_write(16'h0004, 32'd0);
    model_clear();
    base_d = done_cnt;
    bus_write(16'h0000, 32'd1);
    wait_rearm(c, ok);
    chk("s4_rearm_seen", {31'd0, ok}, 32'd1);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    trig_i = 1'b1; addr = 16'h0014; ren = 1'b1; tv = cyc;
    @(negedge clk);
    trig_i = 1'b0; ren = 1'b0;
    chk("s4_empty_pop_rdata", rdata, 32'd0);
    model_push(tv);
    wait_rearm(c, ok);
    chk("s4_rearm2_seen", {31'd0, ok}, 32'd1);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    trig_i = 1'b1; addr = 16'h0000; wdata = 32'd2; wen = 1'b1;
    @(negedge clk);
    trig_i = 1'b0; wen = 1'b0;
    chk("s4_abort_busy", {31'd0, busy_o}, 32'd0);
    chk("s4_abort_rearm", {31'd0, rearm_o}, 32'd0);
    repeat (3) @(negedge clk);
    chk("s4_no_done", 32'(done_cnt - base_d), 32'd0);
    bus_read(16'h0000, rd); chk("s4_ctrl", rd, exp_ctrl(3'd0));
    bus_read(16'h0010, rd); chk("s4_status", rd, exp_status(1'b0));
    pop_check("s4_pop");
    bus_read(16'h0020, rd); chk("s4_unmapped", rd, 32'd0);
    chk("s4_unmapped_ack", {31'd0, last_ack}, 32'd1);

    // Reset asserted while in holdoff.
    bus_write(16'h0008, 32'd50);
    base_d = done_cnt;
    bus_write(16'h0000, 32'd1);
    wait_rearm(c, ok);
    chk("s5_rearm_seen", {31'd0, ok}, 32'd1);
    pulse_trig(2, tv);
    repeat (3) @(negedge clk);
    chk("s5_busy_before", {31'd0, busy_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("s5_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("s5_rst_rearm", {31'd0, rearm_o}, 32'd0);
    chk("s5_rst_done", {31'd0, done_o}, 32'd0);
    chk("s5_rst_ack", {31'd0, ack}, 32'd0);
    chk("s5_rst_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    bus_read(16'h0010, rd); chk("s5_status", rd, 32'd0);
    bus_read(16'h0000, rd); chk("s5_ctrl", rd, 32'd0);
    bus_read(16'h0008, rd); chk("s5_holdoff", rd, 32'd0);
    pop_check("s5_pop");
    chk("s5_no_done", 32'(done_cnt - base_d), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/red_pitaya_trigger_sequencer.md
RED_PITAYA_TRIGGER_SEQUENCER -- requirements
Module: red_pitaya_trigger_sequencer

Interface
REQ-001 SHALL have parameter FIFODEPTH, default 8, meaning timestamp FIFO depth (power of 2, 2..16).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic is in this domain.
REQ-003 SHALL have port rst_i, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port trig_i, input, 1, one-cycle trigger pulse from the trigger block.
REQ-005 SHALL have port rearm_o, output, 1, one-cycle rearm request to the trigger block.
REQ-006 SHALL have port busy_o, output, 1, high in ARM, WAIT and HOLDOFF.
REQ-007 SHALL have port done_o, output, 1, one-cycle pulse on entry to DONE.
REQ-008 SHALL have bus ports addr (16, in), wen (1, in), ren (1, in), ack (1, out, reg), rdata (32, out, reg), wdata (32, in).

Function
REQ-009 SHALL register ack <= wen|ren every cycle, with rdata valid in the same cycle as ack.
REQ-010 SHALL map 0x00: write bit0=start pulse, bit1=abort pulse; read {24'b0, fifo_count[4:0], state[2:0]}.
REQ-011 SHALL map 0x04 n_triggers (16b, R/W, 0 = unlimited), 0x08 holdoff (32b, R/W), 0x0C timeout (32b, R/W, 0 = disabled).
REQ-012 SHALL map 0x10 read-only {14'b0, timeout_flag, overflow_flag, trig_count[15:0]}.
REQ-013 SHALL map 0x14 read: returns FIFO head timestamp and pops it; if empty, returns 0 with no pop.
REQ-014 SHALL return 0 on reads of unmapped addresses, with ack still asserted.
REQ-015 SHALL keep a free-running 32b timestamp counter, +1 per cycle, wrapping 0xFFFFFFFF->0.
REQ-016 SHALL encode states IDLE=0, ARM=1, WAIT=2, HOLDOFF=3, DONE=4.
REQ-017 SHALL, on start in IDLE or DONE: clear trig_count, both flags and the FIFO, then enter ARM next cycle; start is ignored in other states.
REQ-018 SHALL assert rearm_o for exactly the one cycle spent in ARM, then enter WAIT.
REQ-019 SHALL, in WAIT with trig_i=1: push the timestamp counter value, increment trig_count, and go to DONE if trig_count+1==n_triggers (n_triggers != 0); otherwise go to HOLDOFF.
REQ-020 SHALL count exactly holdoff cycles in HOLDOFF, then enter ARM; holdoff=0 enters ARM on the next cycle.
REQ-021 SHALL, in WAIT with timeout != 0, enter DONE and set timeout_flag when timeout cycles elapse without trig_i; the wait timer restarts on each WAIT entry.
REQ-022 SHALL ignore trig_i outside WAIT, with no push and no count.
REQ-023 SHALL, on abort in any state, enter IDLE next cycle with no done_o; FIFO, count and flags are retained.
REQ-024 SHALL give abort priority when abort and trig_i coincide: no push, no count.
REQ-025 SHALL, on push to a full FIFO without a simultaneous pop, drop the sample, set sticky overflow_flag, and still increment trig_count.
REQ-026 SHALL, on simultaneous push and pop: when full, pop then store; when empty, the read returns 0 and the pushed value is stored.
REQ-027 SHALL saturate trig_count at 0xFFFF in unlimited mode.
REQ-028 SHALL take effect on the next ARM/WAIT entry when n_triggers, holdoff or timeout are written mid-sequence.

Reset
REQ-029 SHALL, while rst_i=1: state=IDLE, rearm_o=0, busy_o=0, done_o=0, ack=0, rdata=0, all registers/counters/flags=0, FIFO empty.
REQ-030 SHALL, on reset mid-sequence, abandon the sequence immediately with no done_o and no rearm_o.

Verification
REQ-031 SHALL check: n_triggers=3, holdoff=10, start, trig_i 5 cycles after each rearm_o -> 3 rearm_o pulses spaced >=11 cycles, done_o once, 0x10 reads 3, three ascending timestamps popped, then 0.
REQ-032 SHALL check: timeout=100, start, no trig_i -> DONE exactly 100 cycles after WAIT entry, timeout_flag=1, trig_count=0.
REQ-033 SHALL check: FIFODEPTH=8, n_triggers=10, no pops -> 8 entries, overflow_flag=1, trig_count=10.
REQ-034 SHALL check: abort in the same cycle as trig_i in WAIT -> IDLE next cycle, FIFO count unchanged, no done_o.
REQ-035 SHALL check: assert rst_i during HOLDOFF -> all outputs 0 immediately; status reads 0 after release.
REQ-036 SHALL check: start while busy -> ignored; trig_i in HOLDOFF -> not counted.
